id_ex_stage: RTL and testbench

Decode-to-execute pipeline register with load-use interlock and branch-flush control for the 5-stage RISC-V pipeline core. Captures decoded control and operand data each cycle and presents the E-stage view (Rs1_E, Rs2_E, RD_E and the E controls) consumed by the forwarding hazard unit and the execute stage. Detects the load-use hazard that forwarding cannot cover, stalls Fetch/Decode and inserts a bubble. Squashes wrong-path instructions when a branch resolves taken in Execute.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/id_ex_stage_load_use_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, ResultSrc and ALUControl encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;   // register index width
  localparam int RES_W = 2;   // ResultSrc width
  localparam int ALU_W = 3;   // ALUControl width

  // Write-back result source select
  localparam logic [RES_W-1:0] RES_ALU = 2'b00;
  localparam logic [RES_W-1:0] RES_MEM = 2'b01;
  localparam logic [RES_W-1:0] RES_PC4 = 2'b10;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Flags a Decode instruction that reads the destination of a load currently in Execute.
// Latency: purely combinational.
// Backpressure: none; the caller turns load_use into stalls and a bubble.
// Ports: E-stage load info (ResultSrcE, ValidE, RD_E), D-stage sources (ValidD, Rs1_D, Rs2_D) -> load_use.
module load_use_detect
  import riscv_pkg::*;
(
  input  logic [RES_W-1:0] ResultSrcE,
  input  logic             ValidE,
  input  logic [REG_W-1:0] RD_E,
  input  logic             ValidD,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  output logic             load_use
);

  // x0 never carries a load result, so it cannot create a dependency.
  assign load_use = (ResultSrcE == RES_MEM) && ValidE && (RD_E != '0) && ValidD &&
                    ((RD_E == Rs1_D) || (RD_E == Rs2_D));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, branch flush and a stall counter.
// Latency: D inputs appear on E outputs one cycle after the capturing edge.
// Backpressure: StallF/StallD hold upstream for one cycle on load-use; a bubble is inserted instead.
// Ports: clk/rst; D-stage controls/data/indices in; PCSrcE in; E-stage controls/data/indices out;
//        StallF, StallD, FlushD out (combinational); StallCount out (saturating bubble count).
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             ALUSrcD,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [XLEN-1:0]  RD1_D,
  input  logic [XLEN-1:0]  RD2_D,
  input  logic [XLEN-1:0]  Imm_Ext_D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       RD_D,
  input  logic             PCSrcE,
  output logic             ValidE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             ALUSrcE,
  output logic             BranchE,
  output logic             JumpE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       ALUControlE,
  output logic [XLEN-1:0]  RD1_E,
  output logic [XLEN-1:0]  RD2_E,
  output logic [XLEN-1:0]  Imm_Ext_E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1_E,
  output logic [4:0]       Rs2_E,
  output logic [4:0]       RD_E,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] StallCount
);

  logic load_use;
  logic stall;
  logic bubble;

  load_use_detect u_load_use_detect (
    .ResultSrcE (ResultSrcE),
    .ValidE     (ValidE),
    .RD_E       (RD_E),
    .ValidD     (ValidD),
    .Rs1_D      (Rs1_D),
    .Rs2_D      (Rs2_D),
    .load_use   (load_use)
  );

  // A taken branch makes the Decode instruction wrong-path: flush it rather than stall for it.
  assign stall  = load_use && !PCSrcE;
  assign StallF = stall;
  assign StallD = stall;
  assign FlushD = PCSrcE;
  assign bubble = load_use || PCSrcE;

  // Bubble is all-zero, including Rs/RD, so the hazard unit never forwards into it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ResultSrcE  <= RES_ALU;
      ALUControlE <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1_E       <= '0;
      Rs2_E       <= '0;
      RD_E        <= '0;
    end else if (bubble) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      BranchE     <= 1'b0;
      JumpE       <= 1'b0;
      ResultSrcE  <= RES_ALU;
      ALUControlE <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1_E       <= '0;
      Rs2_E       <= '0;
      RD_E        <= '0;
    end else begin
      ValidE      <= ValidD;
      RegWriteE   <= RegWriteD;
      MemWriteE   <= MemWriteD;
      ALUSrcE     <= ALUSrcD;
      BranchE     <= BranchD;
      JumpE       <= JumpD;
      ResultSrcE  <= ResultSrcD;
      ALUControlE <= ALUControlD;
      RD1_E       <= RD1_D;
      RD2_E       <= RD2_D;
      Imm_Ext_E   <= Imm_Ext_D;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1_E       <= Rs1_D;
      Rs2_E       <= Rs2_D;
      RD_E        <= RD_D;
    end
  end

  // Counts only real stalls; a flushed load-use costs no stall cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
    end else if (stall && (StallCount != {CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ValidD, RegWriteD, MemWriteD, ALUSrcD, BranchD, JumpD;
  logic [1:0]       ResultSrcD;
  logic [2:0]       ALUControlD;
  logic [XLEN-1:0]  RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D;
  logic [4:0]       Rs1_D, Rs2_D, RD_D;
  logic             PCSrcE;
  logic             ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [1:0]       ResultSrcE;
  logic [2:0]       ALUControlE;
  logic [XLEN-1:0]  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]       Rs1_E, Rs2_E, RD_E;
  logic             StallF, StallD, FlushD;
  logic [CNT_W-1:0] StallCount;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
    .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_Ext_D(Imm_Ext_D), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .RD_D(RD_D), .PCSrcE(PCSrcE),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .StallCount(StallCount)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a Decode instruction; remaining fields get fixed recognisable values.
  task automatic set_d(input logic v, input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] rd,
                       input logic [31:0] rd1);
    ValidD = v; RegWriteD = rw; MemWriteD = mw; ResultSrcD = rs;
    Rs1_D = s1; Rs2_D = s2; RD_D = rd; RD1_D = rd1;
    ALUSrcD = 1'b1; BranchD = 1'b0; JumpD = 1'b0; ALUControlD = 3'b010;
    RD2_D = 32'h0000_0022; Imm_Ext_D = 32'h0000_0044;
    PCD = 32'h0000_0100; PCPlus4D = 32'h0000_0104;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; PCSrcE = 1'b0;
    set_d(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0);
    tick(); tick();

    // Reset state
    check_val("rst_ValidE", ValidE, 0);
    check_val("rst_RD_E", RD_E, 0);
    check_val("rst_RD1_E", RD1_E, 0);
    check_val("rst_StallCount", StallCount, 0);
    check_val("rst_StallF", StallF, 0);
    check_val("rst_FlushD", FlushD, 0);
    rst = 1'b0;

    // Plain flow: ADD x3,x1,x2
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 5'd1, 5'd2, 5'd3, 32'h0000_0011);
    tick();
    check_val("add_RD_E", RD_E, 3);
    check_val("add_RegWriteE", RegWriteE, 1);
    check_val("add_ValidE", ValidE, 1);
    check_val("add_RD1_E", RD1_E, 32'h11);
    check_val("add_PCPlus4E", PCPlus4E, 32'h104);
    check_val("add_ALUControlE", ALUControlE, 3'b010);
    check_val("add_StallF", StallF, 0);
    check_val("add_StallCount", StallCount, 0);

    // Load-use: LW x5 then ADD x6,x5,x1
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd5, 32'h0);
    tick();
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 5'd5, 5'd1, 5'd6, 32'h0000_00AA);
    #1;
    check_val("lu_StallF", StallF, 1);
    check_val("lu_StallD", StallD, 1);
    check_val("lu_FlushD", FlushD, 0);
    tick();
    check_val("lu_bubble_ValidE", ValidE, 0);
    check_val("lu_bubble_RD_E", RD_E, 0);
    check_val("lu_bubble_Rs1_E", Rs1_E, 0);
    check_val("lu_bubble_RegWriteE", RegWriteE, 0);
    check_val("lu_bubble_RD1_E", RD1_E, 0);
    check_val("lu_bubble_ALUSrcE", ALUSrcE, 0);
    check_val("lu_released_StallF", StallF, 0);
    check_val("lu_StallCount", StallCount, 1);
    tick();
    check_val("lu_adv_RD_E", RD_E, 6);
    check_val("lu_adv_RD1_E", RD1_E, 32'hAA);
    check_val("lu_adv_ValidE", ValidE, 1);
    check_val("lu_adv_StallCount", StallCount, 1);

    // Store consuming load result through Rs2
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd7, 32'h0);
    tick();
    set_d(1'b1, 1'b0, 1'b1, 2'b00, 5'd1, 5'd7, 5'd0, 32'h0);
    #1;
    check_val("st_StallF", StallF, 1);
    tick();
    check_val("st_StallCount", StallCount, 2);
    tick();
    check_val("st_adv_MemWriteE", MemWriteE, 1);

    // x0 destination never stalls
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd0, 32'h0);
    tick();
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'd8, 32'h0);
    #1;
    check_val("x0_StallF", StallF, 0);

    // Invalid D never triggers load-use but still propagates its controls
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd5, 32'h0);
    tick();
    set_d(1'b0, 1'b1, 1'b0, 2'b00, 5'd5, 5'd0, 5'd9, 32'h0);
    #1;
    check_val("inv_StallF", StallF, 0);
    tick();
    check_val("inv_ValidE", ValidE, 0);
    check_val("inv_RegWriteE", RegWriteE, 1);
    check_val("inv_RD_E", RD_E, 9);
    check_val("inv_StallCount", StallCount, 2);

    // Branch taken has priority over load-use
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd5, 32'h0);
    tick();
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 5'd5, 5'd0, 5'd10, 32'h0);
    PCSrcE = 1'b1;
    #1;
    check_val("br_StallF", StallF, 0);
    check_val("br_StallD", StallD, 0);
    check_val("br_FlushD", FlushD, 1);
    tick();
    PCSrcE = 1'b0;
    check_val("br_bubble_ValidE", ValidE, 0);
    check_val("br_bubble_RD_E", RD_E, 0);
    check_val("br_StallCount", StallCount, 2);

    // Plain taken branch with no hazard also flushes and bubbles
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 5'd1, 5'd2, 5'd11, 32'h55);
    PCSrcE = 1'b1;
    tick();
    PCSrcE = 1'b0;
    check_val("br2_RD_E", RD_E, 0);

    // Saturation: 16 more stalls from 2 -> capped at 15
    for (int i = 0; i < 16; i++) begin
      set_d(1'b1, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd5, 32'h0);
      tick();
      set_d(1'b1, 1'b1, 1'b0, 2'b00, 5'd5, 5'd0, 5'd12, 32'h0);
      tick();
    end
    check_val("sat_StallCount", StallCount, 15);
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd5, 32'h0);
    tick();
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 5'd0, 5'd5, 5'd12, 32'h0);
    #1;
    check_val("sat_StallF", StallF, 1);
    tick();
    check_val("sat_hold_StallCount", StallCount, 15);

    // Async reset mid-stall
    set_d(1'b1, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd5, 32'h0);
    tick();
    set_d(1'b1, 1'b1, 1'b0, 2'b00, 5'd5, 5'd0, 5'd13, 32'h0);
    #1;
    check_val("ar_pre_StallF", StallF, 1);
    #1;
    rst = 1'b1;
    #1;
    check_val("ar_StallF", StallF, 0);
    check_val("ar_StallD", StallD, 0);
    check_val("ar_ValidE", ValidE, 0);
    check_val("ar_RD_E", RD_E, 0);
    check_val("ar_ResultSrcE", ResultSrcE, 0);
    check_val("ar_StallCount", StallCount, 0);
    tick();
    rst = 1'b0;
    tick();
    check_val("post_rst_RD_E", RD_E, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
